// File: rtl/fp_mac_pkg.sv
// rtl/fp_mac_pkg.sv - shared format defaults and helpers for the fp MAC processing element
package fp_mac_pkg;

  localparam int EW_DEF = 3;
  localparam int FW_DEF = 4;
  localparam int W_DEF  = 1 + EW_DEF + FW_DEF;

  // Exponent bias for an ew-bit exponent field
  function automatic int bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  // Largest biased exponent; every exponent code is a normal number
  function automatic int exp_max(input int ew);
    return (1 << ew) - 1;
  endfunction

  // Magnitude bits {exponent, fraction} of the largest finite value
  function automatic int max_mag(input int ew, input int fw);
    return (1 << (ew + fw)) - 1;
  endfunction

  // Bit position of the sign in {sign, exponent, fraction}
  function automatic int sign_pos(input int ew, input int fw);
    return ew + fw;
  endfunction

  // Lowest bit of the exponent field
  function automatic int exp_lsb(input int fw);
    return fw;
  endfunction

endpackage

// File: rtl/fp_mul.sv
// rtl/fp_mul.sv - stage-1 floating-point multiplier with its output register
module fp_mul
  import fp_mac_pkg::*;
#(
  parameter int  EW  = EW_DEF,
  parameter int  FW  = FW_DEF,
  localparam int W   = 1 + EW + FW,
  localparam int EXW = EW + 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           prod_valid,
  output logic           prod_sign,
  output logic           prod_zero,
  output logic [EXW-1:0] prod_exp,
  output logic [FW-1:0]  prod_frac
);

  localparam int SW   = FW + 1;
  localparam int BIAS = bias(EW);
  localparam int SP   = sign_pos(EW, FW);
  localparam int EL   = exp_lsb(FW);

  logic            a_zero;
  logic            b_zero;
  logic            norm;
  logic [SW-1:0]   sig_a;
  logic [SW-1:0]   sig_b;
  logic [2*SW-1:0] sig_p;
  logic [EXW-1:0]  exp_p;
  logic [FW-1:0]   frac_p;

  // Product of the two operands; exponent kept wide so range checks happen after accumulation
  always_comb begin
    a_zero = (a[SP-1:0] == '0);
    b_zero = (b[SP-1:0] == '0);
    sig_a  = {1'b1, a[FW-1:0]};
    sig_b  = {1'b1, b[FW-1:0]};
    sig_p  = sig_a * sig_b;
    norm   = sig_p[2*SW-1];
    exp_p  = EXW'(a[SP-1:EL]) + EXW'(b[SP-1:EL]) - EXW'(BIAS) + EXW'(norm);
    frac_p = norm ? FW'(sig_p >> (FW + 1)) : FW'(sig_p >> FW);
  end

  // Stage-1 pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_valid <= 1'b0;
      prod_sign  <= 1'b0;
      prod_zero  <= 1'b1;
      prod_exp   <= '0;
      prod_frac  <= '0;
    end else begin
      prod_valid <= in_valid;
      prod_sign  <= a[SP] ^ b[SP];
      prod_zero  <= a_zero | b_zero;
      prod_exp   <= exp_p;
      prod_frac  <= frac_p;
    end
  end

endmodule

// File: rtl/fp_mac_pe.sv
// rtl/fp_mac_pe.sv - systolic floating-point multiply-accumulate processing element
module fp_mac_pe
  import fp_mac_pkg::*;
#(
  parameter int  EW = EW_DEF,
  parameter int  FW = FW_DEF,
  localparam int W  = 1 + EW + FW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         acc_clr,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic [W-1:0] a_pass,
  output logic [W-1:0] b_pass,
  output logic         pass_valid,
  output logic [W-1:0] acc_out,
  output logic         out_valid,
  output logic         ovf,
  output logic         uf
);

  localparam int EXW = EW + 3;
  localparam int SW  = FW + 1;
  localparam int SP  = sign_pos(EW, FW);
  localparam int EL  = exp_lsb(FW);
  localparam logic signed [EXW-1:0] EMAX_S  = EXW'(exp_max(EW));
  localparam logic [EW+FW-1:0]      MAX_MAG = (EW + FW)'(max_mag(EW, FW));

  logic                  p_valid;
  logic                  p_sign;
  logic                  p_zero;
  logic [EXW-1:0]        p_exp;
  logic [FW-1:0]         p_frac;

  logic                  x_zero;
  logic                  xs;
  logic                  big_s;
  logic                  small_s;
  logic                  res_s;
  logic                  found;
  logic signed [EXW-1:0] xe;
  logic signed [EXW-1:0] ye;
  logic signed [EXW-1:0] big_e;
  logic signed [EXW-1:0] small_e;
  logic signed [EXW-1:0] norm_e;
  logic [EXW-1:0]        shamt;
  logic [SW-1:0]         xm;
  logic [SW-1:0]         ym;
  logic [SW-1:0]         big_m;
  logic [SW-1:0]         small_m;
  logic [SW-1:0]         small_al;
  logic [SW:0]           sum;
  logic [SW:0]           norm_m;
  int                    lz;
  logic [W-1:0]          res_word;
  logic                  res_ovf;
  logic                  res_uf;

  // Forward operands to the neighbouring PE; these registers also feed the multiplier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_pass     <= '0;
      b_pass     <= '0;
      pass_valid <= 1'b0;
    end else begin
      a_pass     <= a_in;
      b_pass     <= b_in;
      pass_valid <= in_valid;
    end
  end

  fp_mul #(
    .EW(EW),
    .FW(FW)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (pass_valid),
    .a         (a_pass),
    .b         (b_pass),
    .prod_valid(p_valid),
    .prod_sign (p_sign),
    .prod_zero (p_zero),
    .prod_exp  (p_exp),
    .prod_frac (p_frac)
  );

  // Align, add, renormalise and range-check accumulator plus product; a clear makes the accumulator read as zero
  always_comb begin
    x_zero = acc_clr | (acc_out[SP-1:0] == '0);
    xs     = acc_out[SP];
    xm     = x_zero ? '0 : {1'b1, acc_out[FW-1:0]};
    ym     = p_zero ? '0 : {1'b1, p_frac};
    xe     = x_zero ? $signed(p_exp) : $signed(EXW'(acc_out[SP-1:EL]));
    ye     = p_zero ? $signed(EXW'(acc_out[SP-1:EL])) : $signed(p_exp);

    if (xe >= ye) begin
      big_s = xs;     big_e = xe;   big_m = xm;
      small_s = p_sign; small_e = ye; small_m = ym;
    end else begin
      big_s = p_sign; big_e = ye;   big_m = ym;
      small_s = xs;   small_e = xe; small_m = xm;
    end

    shamt    = big_e - small_e;
    small_al = small_m >> shamt;

    if (big_s == small_s) begin
      sum   = {1'b0, big_m} + {1'b0, small_al};
      res_s = big_s;
    end else if (big_m >= small_al) begin
      sum   = {1'b0, big_m - small_al};
      res_s = big_s;
    end else begin
      sum   = {1'b0, small_al - big_m};
      res_s = small_s;
    end

    lz    = 0;
    found = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!found) begin
        if (sum[i]) found = 1'b1;
        else        lz = lz + 1;
      end
    end

    if (sum[SW]) begin
      norm_m = sum >> 1;
      norm_e = big_e + EXW'(1);
    end else begin
      norm_m = sum << lz;
      norm_e = big_e - EXW'(lz);
    end

    res_word = '0;
    res_ovf  = 1'b0;
    res_uf   = 1'b0;
    if (sum == '0) begin
      res_word = '0;
    end else if (norm_e > EMAX_S) begin
      res_word = {res_s, MAX_MAG};
      res_ovf  = 1'b1;
    end else if (norm_e[EXW-1]) begin
      res_uf = 1'b1;
    end else begin
      res_word = {res_s, norm_e[EW-1:0], FW'(norm_m)};
    end
  end

  // Accumulator and sticky flags; a clear without a product just zeroes state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_out   <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      uf        <= 1'b0;
    end else begin
      out_valid <= p_valid;
      if (p_valid) begin
        acc_out <= res_word;
        ovf     <= (ovf & ~acc_clr) | res_ovf;
        uf      <= (uf & ~acc_clr) | res_uf;
      end else if (acc_clr) begin
        acc_out <= '0;
        ovf     <= 1'b0;
        uf      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_mac_pe.sv
// tb/tb_fp_mac_pe.sv - self-checking bench for fp_mac_pe
module tb_fp_mac_pe;

  localparam int EW   = 3;
  localparam int FW   = 4;
  localparam int W    = 8;
  localparam int BIAS = 3;
  localparam int EMAX = 7;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         acc_clr;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] a_pass;
  logic [W-1:0] b_pass;
  logic         pass_valid;
  logic [W-1:0] acc_out;
  logic         out_valid;
  logic         ovf;
  logic         uf;

  int n_chk  = 0;
  int n_fail = 0;

  // reference state
  logic [W-1:0] mpa = '0, mpb = '0, macc = '0;
  bit           mpv = 0, ppv = 0, mov = 0, movf = 0, muf = 0;
  int           ps = 0, pe = -100, pm = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           clr;
    logic [W-1:0] acc;
    bit           o;
    bit           u;
  } vec_t;

  vec_t tbl[13];

  fp_mac_pe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .acc_clr   (acc_clr),
    .a_in      (a_in),
    .b_in      (b_in),
    .a_pass    (a_pass),
    .b_pass    (b_pass),
    .pass_valid(pass_valid),
    .acc_out   (acc_out),
    .out_valid (out_valid),
    .ovf       (ovf),
    .uf        (uf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // value = m * 2^(e - BIAS - FW); zero has m = 0
  function automatic void m_decode(input logic [W-1:0] w, output int s, output int e, output int m);
    s = int'(w[W-1]);
    e = int'(w[W-2:FW]);
    m = int'(w[FW-1:0]);
    if (e == 0 && m == 0) e = -100;
    else m = m + (1 << FW);
  endfunction

  function automatic void m_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                output int s, output int e, output int m);
    int sa, ea, ma, sb, eb, mb;
    m_decode(a, sa, ea, ma);
    m_decode(b, sb, eb, mb);
    s = sa ^ sb;
    if (ma == 0 || mb == 0) begin
      e = -100;
      m = 0;
    end else begin
      m = (ma * mb) >> FW;
      e = ea + eb - BIAS;
      if (m >= (1 << (FW + 1))) begin
        m = m >> 1;
        e = e + 1;
      end
    end
  endfunction

  function automatic void m_add(input int s1, input int e1, input int m1,
                                input int s2, input int e2, input int m2,
                                output logic [W-1:0] w, output bit o, output bit u);
    int e, a1, a2, sum, sg, mag;
    w = '0;
    o = 0;
    u = 0;
    e  = (e1 > e2) ? e1 : e2;
    a1 = (e - e1 > 30) ? 0 : (m1 >> (e - e1));
    a2 = (e - e2 > 30) ? 0 : (m2 >> (e - e2));
    sum = (s1 != 0 ? -a1 : a1) + (s2 != 0 ? -a2 : a2);
    if (sum == 0) return;
    sg  = (sum < 0) ? 1 : 0;
    mag = (sum < 0) ? -sum : sum;
    while (mag >= (1 << (FW + 1))) begin mag = mag >> 1; e = e + 1; end
    while (mag < (1 << FW)) begin mag = mag << 1; e = e - 1; end
    if (e > EMAX) begin
      o = 1;
      w = W'((sg << (W - 1)) | ((1 << (W - 1)) - 1));
    end else if (e < 0) begin
      u = 1;
    end else begin
      w = W'((sg << (W - 1)) | (e << FW) | (mag - (1 << FW)));
    end
  endfunction

  task automatic check_all();
    chk("acc_out", 32'(acc_out), 32'(macc));
    chk("out_valid", 32'(out_valid), 32'(mov));
    chk("ovf", 32'(ovf), 32'(movf));
    chk("uf", 32'(uf), 32'(muf));
    chk("a_pass", 32'(a_pass), 32'(mpa));
    chk("b_pass", 32'(b_pass), 32'(mpb));
    chk("pass_valid", 32'(pass_valid), 32'(mpv));
  endtask

  task automatic model_clear();
    macc = '0; movf = 0; muf = 0; mov = 0;
    mpa = '0; mpb = '0; mpv = 0;
    ppv = 0; ps = 0; pe = -100; pm = 0;
  endtask

  // called at a falling edge: drive, clock once, advance the model, check
  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input bit v, input bit c);
    logic [W-1:0] w;
    bit o, u;
    int xs, xe, xm;
    a_in = a; b_in = b; in_valid = v; acc_clr = c;
    @(posedge clk);
    if (ppv) begin
      if (c) begin xs = 0; xe = -100; xm = 0; end
      else m_decode(macc, xs, xe, xm);
      m_add(xs, xe, xm, ps, pe, pm, w, o, u);
      macc = w;
      movf = (movf & !c) | o;
      muf  = (muf & !c) | u;
      mov  = 1;
    end else begin
      mov = 0;
      if (c) begin macc = '0; movf = 0; muf = 0; end
    end
    ppv = mpv;
    m_mul(mpa, mpb, ps, pe, pm);
    mpa = a; mpb = b; mpv = v;
    @(negedge clk);
    check_all();
  endtask

  // called at a falling edge: asynchronous assert, hold over one rising edge, release
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_acc_out", 32'(acc_out), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_uf", 32'(uf), 32'h0);
    chk("rst_a_pass", 32'(a_pass), 32'h0);
    chk("rst_b_pass", 32'(b_pass), 32'h0);
    chk("rst_pass_valid", 32'(pass_valid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    tbl[0]  = '{8'h30, 8'h30, 1'b1, 8'h30, 1'b0, 1'b0};
    tbl[1]  = '{8'h30, 8'h30, 1'b0, 8'h40, 1'b0, 1'b0};
    tbl[2]  = '{8'h38, 8'h38, 1'b1, 8'h42, 1'b0, 1'b0};
    tbl[3]  = '{8'h30, 8'h30, 1'b1, 8'h30, 1'b0, 1'b0};
    tbl[4]  = '{8'hB0, 8'h30, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[5]  = '{8'h70, 8'h40, 1'b1, 8'h7F, 1'b1, 1'b0};
    tbl[6]  = '{8'hF0, 8'h40, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[7]  = '{8'h10, 8'h10, 1'b1, 8'h00, 1'b0, 1'b1};
    tbl[8]  = '{8'h00, 8'h55, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[9]  = '{8'h80, 8'h55, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[10] = '{8'h7F, 8'h30, 1'b1, 8'h7F, 1'b0, 1'b0};
    tbl[11] = '{8'h01, 8'h30, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[12] = '{8'h3F, 8'h3F, 1'b1, 8'h4E, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; acc_clr = 1'b0; a_in = '0; b_in = '0;
    @(negedge clk);
    chk("init_acc_out", 32'(acc_out), 32'h0);
    chk("init_out_valid", 32'(out_valid), 32'h0);
    chk("init_pass_valid", 32'(pass_valid), 32'h0);
    chk("init_flags", 32'({ovf, uf}), 32'h0);
    rst_n = 1'b1;
    model_clear();

    // directed vectors
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].clr) step('0, '0, 0, 1);
      step(tbl[i].a, tbl[i].b, 1, 0);
      step('0, '0, 0, 0);
      step('0, '0, 0, 0);
      chk($sformatf("vec%0d_acc", i), 32'(acc_out), 32'(tbl[i].acc));
      chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(tbl[i].o));
      chk($sformatf("vec%0d_uf", i), 32'(uf), 32'(tbl[i].u));
    end

    // two-cycle latency and single-cycle out_valid pulse
    step('0, '0, 0, 1);
    step(8'h30, 8'h30, 1, 0);
    chk("lat_pass_valid", 32'(pass_valid), 32'h1);
    chk("lat_a_pass", 32'(a_pass), 32'h30);
    chk("lat_ov_t0", 32'(out_valid), 32'h0);
    step('0, '0, 0, 0);
    chk("lat_ov_t1", 32'(out_valid), 32'h0);
    step('0, '0, 0, 0);
    chk("lat_ov_t2", 32'(out_valid), 32'h1);
    chk("lat_acc_t2", 32'(acc_out), 32'h30);
    step('0, '0, 0, 0);
    chk("lat_ov_t3", 32'(out_valid), 32'h0);

    // clear alone drops ovf and the accumulator without a pulse
    step('0, '0, 0, 1);
    step(8'h70, 8'h40, 1, 0);
    step('0, '0, 0, 0);
    step('0, '0, 0, 0);
    chk("sat_ovf_set", 32'(ovf), 32'h1);
    step('0, '0, 0, 1);
    chk("clr_ovf", 32'(ovf), 32'h0);
    chk("clr_acc", 32'(acc_out), 32'h0);
    chk("clr_no_pulse", 32'(out_valid), 32'h0);

    // clear coincident with a product loads that product alone
    step('0, '0, 0, 1);
    step(8'h30, 8'h30, 1, 0);
    step(8'h40, 8'h30, 1, 0);
    step('0, '0, 0, 0);
    chk("coin_first", 32'(acc_out), 32'h30);
    step('0, '0, 0, 1);
    chk("coin_acc", 32'(acc_out), 32'h40);
    chk("coin_pulse", 32'(out_valid), 32'h1);

    // back-to-back pairs with reset in the middle
    step(8'h30, 8'h30, 1, 0);
    step(8'h30, 8'h30, 1, 0);
    in_valid = 1'b1;
    do_reset();
    step(8'h30, 8'h30, 1, 0);
    step(8'h30, 8'h30, 1, 0);
    step('0, '0, 0, 0);
    step('0, '0, 0, 0);
    step('0, '0, 0, 0);
    chk("rst_restart_acc", 32'(acc_out), 32'h40);

    // randomized traffic against the reference model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
      end else begin
        ra = W'($urandom);
        rb = W'($urandom);
        if ($urandom_range(0, 1) == 1) ra = {1'($urandom), 3'($urandom_range(1, 5)), 4'($urandom)};
        if ($urandom_range(0, 1) == 1) rb = {1'($urandom), 3'($urandom_range(1, 5)), 4'($urandom)};
        step(ra, rb, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
